// File: rtl/iq_magnitude.sv
// Computes floor(sqrt(I^2 + Q^2)) for one signed I/Q pair.
// The two squares share one shift-add multiplier; the root comes from an external sqrt_fixed.
//   state | meaning
//   IDLE  | waiting for start
//   SQ_I  | shift-add |I|^2 into accumulator
//   SQ_Q  | shift-add |Q|^2 into accumulator
//   REQ   | offering the sum to sqrt_fixed
//   WAIT  | waiting for the sqrt result
module iq_magnitude #(
  parameter int IQ_WIDTH  = 16,
  parameter int SUM_WIDTH = 2*IQ_WIDTH,
  parameter int MAG_WIDTH = IQ_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [IQ_WIDTH-1:0]  i_in,
  input  logic [IQ_WIDTH-1:0]  q_in,
  output logic                 busy,
  output logic                 done,
  output logic [MAG_WIDTH-1:0] mag_out,
  output logic                 sqrt_input_ready,
  output logic [SUM_WIDTH-1:0] sqrt_in,
  input  logic                 sqrt_flag_new_input,
  input  logic                 sqrt_in_use,
  input  logic                 sqrt_output_ready,
  input  logic [MAG_WIDTH-1:0] sqrt_out
);
  localparam int CW = (IQ_WIDTH > 1) ? $clog2(IQ_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, SQ_I, SQ_Q, REQ, WAIT} state_t;

  state_t               state, state_next;
  logic [SUM_WIDTH-1:0] acc, mcand, acc_add;
  logic [IQ_WIDTH-1:0]  mplier, abs_q;
  logic [IQ_WIDTH-1:0]  abs_i_in, abs_q_in;
  logic [CW-1:0]        bit_cnt;
  logic                 last_bit;
  logic                 sqrt_in_use_unused;

  // the most negative input maps to 2^(IQ_WIDTH-1), which is still representable unsigned
  assign abs_i_in = i_in[IQ_WIDTH-1] ? (~i_in + IQ_WIDTH'(1)) : i_in;
  assign abs_q_in = q_in[IQ_WIDTH-1] ? (~q_in + IQ_WIDTH'(1)) : q_in;

  assign acc_add  = mplier[0] ? (acc + mcand) : acc;
  assign last_bit = (bit_cnt == '0);
  assign busy     = (state != IDLE);

  // handshake monitor input only; control never depends on it
  assign sqrt_in_use_unused = sqrt_in_use;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start)               state_next = SQ_I;
      SQ_I: if (last_bit)            state_next = SQ_Q;
      SQ_Q: if (last_bit)            state_next = REQ;
      REQ:  if (sqrt_flag_new_input) state_next = WAIT;
      WAIT: if (sqrt_output_ready)   state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done             <= 1'b0;
      mag_out          <= '0;
      sqrt_input_ready <= 1'b0;
      sqrt_in          <= '0;
      acc              <= '0;
      mcand            <= '0;
      mplier           <= '0;
      abs_q            <= '0;
      bit_cnt          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mcand   <= SUM_WIDTH'(abs_i_in);
          mplier  <= abs_i_in;
          abs_q   <= abs_q_in;
          acc     <= '0;
          bit_cnt <= CW'(IQ_WIDTH-1);
        end
        SQ_I: begin
          acc <= acc_add;
          if (last_bit) begin
            mcand   <= SUM_WIDTH'(abs_q);
            mplier  <= abs_q;
            bit_cnt <= CW'(IQ_WIDTH-1);
          end else begin
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        SQ_Q: begin
          acc     <= acc_add;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt - CW'(1);
          if (last_bit) begin
            sqrt_in          <= acc_add;
            sqrt_input_ready <= 1'b1;
          end
        end
        REQ: if (sqrt_flag_new_input) sqrt_input_ready <= 1'b0;
        WAIT: if (sqrt_output_ready) begin
          mag_out <= sqrt_out;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iq_magnitude.sv
// Self-checking bench for iq_magnitude with a behavioural sqrt_fixed responder.
module tb_iq_magnitude;
  localparam int W  = 16;
  localparam int SW = 2*W;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [W-1:0]  i_in, q_in;
  logic          busy, done;
  logic [W-1:0]  mag_out;
  logic          sqrt_input_ready;
  logic [SW-1:0] sqrt_in;
  logic          sqrt_flag_new_input, sqrt_in_use, sqrt_output_ready;
  logic [W-1:0]  sqrt_out;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ops = 0;

  // behavioural sqrt_fixed: accepts when free, answers 5 cycles later
  logic          hold = 1'b0;
  logic          extra_ready = 1'b0;
  logic [W-1:0]  extra_out = '0;
  logic          m_active = 1'b0;
  int            m_cnt = 0;
  logic [W-1:0]  m_res = '0;

  iq_magnitude #(.IQ_WIDTH(W), .SUM_WIDTH(SW), .MAG_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .i_in(i_in), .q_in(q_in),
    .busy(busy), .done(done), .mag_out(mag_out),
    .sqrt_input_ready(sqrt_input_ready), .sqrt_in(sqrt_in),
    .sqrt_flag_new_input(sqrt_flag_new_input), .sqrt_in_use(sqrt_in_use),
    .sqrt_output_ready(sqrt_output_ready), .sqrt_out(sqrt_out)
  );

  always #5 clk = ~clk;

  function automatic longint isqrt(input longint x);
    longint r = 0;
    for (int b = 20; b >= 0; b--) begin
      longint t = r | (longint'(1) << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  assign sqrt_flag_new_input = sqrt_input_ready && !hold && !m_active;
  assign sqrt_in_use         = hold || m_active;
  assign sqrt_output_ready   = (m_active && m_cnt == 0) || extra_ready;
  assign sqrt_out            = extra_ready ? extra_out : m_res;

  always @(posedge clk) begin
    if (sqrt_flag_new_input) begin
      m_active <= 1'b1;
      m_cnt    <= 4;
      m_res    <= W'(isqrt(longint'(sqrt_in)));
    end else if (m_active) begin
      if (m_cnt == 0) m_active <= 1'b0;
      else            m_cnt    <= m_cnt - 1;
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one request; returns in the cycle where done is high so a new start can follow at once.
  task automatic do_op(input logic signed [W-1:0] i, input logic signed [W-1:0] q,
                       input longint exp_sum, input longint exp_mag, input string tag);
    int c;
    start = 1'b1; i_in = i; q_in = q;
    tick();
    start = 1'b0;
    c = 1;
    while (!sqrt_input_ready && c < 200) begin tick(); c++; end
    check({tag, " latency"}, c, 2*W+1);
    check({tag, " sqrt_in"}, longint'(sqrt_in), exp_sum);
    while (!sqrt_flag_new_input && c < 300) begin tick(); c++; end
    tick(); c++;
    check({tag, " wait busy/in_use/ready"}, {busy, sqrt_in_use, sqrt_input_ready}, 3'b110);
    while (!done && c < 400) begin tick(); c++; end
    check({tag, " done"}, done, 1);
    check({tag, " mag_out"}, mag_out, exp_mag);
    ops++;
  endtask

  typedef struct {
    logic signed [W-1:0] i;
    logic signed [W-1:0] q;
    longint              sum;
    longint              mag;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d0;
    logic [SW-1:0] held;
    bit stable;
    logic signed [W-1:0] ri, rq;
    longint rs;

    vecs[0] = '{16'sd3,      16'sd4,      64'd25,         64'd5};
    vecs[1] = '{-16'sd32768, -16'sd32768, 64'h8000_0000,  64'd46340};
    vecs[2] = '{16'sd0,      16'sd0,      64'd0,          64'd0};
    vecs[3] = '{-16'sd5,     16'sd12,     64'd169,        64'd13};
    vecs[4] = '{16'sd32767,  -16'sd32768, 64'd2147418113, 64'd46340};
    vecs[5] = '{16'sd1,      -16'sd1,     64'd2,          64'd1};

    reset = 1'b1; start = 1'b0; i_in = '0; q_in = '0;
    repeat (3) tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset mag_out", mag_out, 0);
    check("reset sqrt_in", sqrt_in, 0);
    check("reset sqrt_input_ready", sqrt_input_ready, 0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) begin
      do_op(vecs[k].i, vecs[k].q, vecs[k].sum, vecs[k].mag, $sformatf("vec%0d", k));
      tick();
      check($sformatf("vec%0d done width", k), done, 0);
    end

    // back-to-back: start in the done cycle
    do_op(16'sd3, 16'sd4, 25, 5, "b2b first");
    do_op(-16'sd5, 16'sd12, 169, 13, "b2b second");
    repeat (2) tick();

    // start re-pulsed during SQ_Q and WAIT is ignored
    d0 = done_cnt;
    start = 1'b1; i_in = 16'sd3; q_in = 16'sd4;
    tick();
    start = 1'b0;
    repeat (20) tick();
    start = 1'b1; i_in = 16'sd7; q_in = 16'sd0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && !sqrt_input_ready; c++) tick();
    check("ignore sqrt_in", sqrt_in, 25);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && !done; c++) tick();
    check("ignore mag_out", mag_out, 5);
    repeat (60) tick();
    check("ignore done count", done_cnt - d0, 1);
    check("ignore idle", busy, 0);
    ops++;

    // sqrt_fixed busy for 50 cycles: request must be held
    hold = 1'b1;
    start = 1'b1; i_in = 16'sd300; q_in = -16'sd400;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && !sqrt_input_ready; c++) tick();
    held = sqrt_in;
    check("hold sqrt_in", held, 250000);
    stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (!sqrt_input_ready || sqrt_in !== held) stable = 1'b0;
    end
    check("hold stable", stable, 1);
    hold = 1'b0;
    tick();
    check("hold accepted", {sqrt_input_ready, sqrt_in_use}, 2'b01);
    for (int c = 0; c < 100 && !done; c++) tick();
    check("hold mag_out", mag_out, 500);
    ops++;
    repeat (3) tick();

    // reset in WAIT, then late and foreign output_ready pulses
    d0 = done_cnt;
    start = 1'b1; i_in = 16'sd3; q_in = 16'sd4;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && !sqrt_input_ready; c++) tick();
    repeat (2) tick();
    check("pre-reset in WAIT", {busy, sqrt_in_use}, 2'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort outputs", {busy, done, sqrt_input_ready}, 3'b000);
    check("abort mag_out", mag_out, 0);
    check("abort sqrt_in", sqrt_in, 0);
    extra_ready = 1'b1; extra_out = 16'd99;
    tick();
    extra_ready = 1'b0;
    repeat (10) tick();
    check("abort no done", done_cnt - d0, 0);
    check("abort mag_out after", mag_out, 0);
    check("abort idle", busy, 0);

    // randomized against the arithmetic model
    for (int k = 0; k < 20; k++) begin
      ri = W'($urandom);
      rq = W'($urandom);
      if (k == 0) ri = -16'sd32768;
      rs = longint'(ri) * ri + longint'(rq) * rq;
      do_op(ri, rq, rs, isqrt(rs), $sformatf("rand%0d", k));
      repeat ($urandom_range(3, 1)) tick();
    end

    check("total done pulses", done_cnt, ops);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
